// File: rtl/exe_seq_ctrl.sv
// exe_seq_ctrl: execute-stage control sequencer.
// Takes one decoded instruction word per handshake. Each instruction expands into one or
// more beats, and each beat carries a registered execute control word.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   opcode_i          instruction word from decode
//   in_valid_i        opcode_i is valid
//   in_ready_o        opcode_i is accepted this cycle when in_valid_i is high
//   hold_i            downstream freeze
//   cnt_out_o         execute control word (registered)
//   out_valid_o       cnt_out_o is meaningful
//   phase_o           0-based beat index
//   last_o            final beat of the instruction
//   reg_idx_o         register number of the current LDM/STM beat
//   addr_off_o        signed byte offset of the current LDM/STM beat
//   stall_out_o       decode must hold its instruction
module exe_seq_ctrl #(
  parameter int unsigned CNT_W       = 14,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned MULL_CYCLES = 2,
  parameter int unsigned ADDR_STEP   = 4,
  localparam int unsigned PW         = $clog2(NUM_REGS + 2),
  localparam int unsigned RW         = $clog2(NUM_REGS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        opcode_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               hold_i,
  output logic [CNT_W-1:0]   cnt_out_o,
  output logic               out_valid_o,
  output logic [PW-1:0]      phase_o,
  output logic               last_o,
  output logic [RW-1:0]      reg_idx_o,
  output logic signed [15:0] addr_off_o,
  output logic               stall_out_o
);

  typedef enum logic {StIdle, StRun} state_e;
  typedef enum logic [2:0] {ClsDp, ClsMul, ClsMull, ClsLs, ClsBlk, ClsBr} cls_e;

  state_e              state_q;
  cls_e                cls_q;
  logic [3:0]          op_q;      // opcode[23:20]
  logic [PW-1:0]       n_q, nx_q, phase_q;
  logic [NUM_REGS-1:0] mask_q;    // registers still to transfer after the current beat
  logic [CNT_W-1:0]    cnt_q;
  logic                out_valid_q, last_q;
  logic [RW-1:0]       reg_idx_q;
  logic signed [15:0]  addr_off_q;

  cls_e          dec_cls;
  logic [PW-1:0] dec_pop, dec_n;
  logic          accept;

  cls_e                sel_cls;
  logic [3:0]          sel_op;
  logic [PW-1:0]       sel_p, sel_n, sel_nx;
  logic [NUM_REGS-1:0] sel_mask, b_mask_nxt;
  logic [RW-1:0]       b_idx, b_reg;
  logic                b_last;
  logic [13:0]         c14;
  int                  off_int;

  logic unused_opcode;
  assign unused_opcode = ^opcode_i;

  assign in_ready_o  = !hold_i && (state_q == StIdle || last_q);
  assign accept      = in_valid_i && in_ready_o;
  assign stall_out_o = (state_q == StRun) && !last_q;

  // Instruction decode; first match wins.
  always_comb begin
    dec_cls = ClsDp;
    if (opcode_i[27:22] == 6'b000000 && opcode_i[7:4] == 4'b1001)     dec_cls = ClsMul;
    else if (opcode_i[27:23] == 5'b00001 && opcode_i[7:4] == 4'b1001) dec_cls = ClsMull;
    else if (opcode_i[27:26] == 2'b01)                                dec_cls = ClsLs;
    else if (opcode_i[27:25] == 3'b100)                               dec_cls = ClsBlk;
    else if (opcode_i[27:25] == 3'b101)                               dec_cls = ClsBr;

    dec_pop = '0;
    for (int i = 0; i < NUM_REGS; i++) dec_pop = dec_pop + PW'(opcode_i[i]);

    case (dec_cls)
      ClsMull: dec_n = PW'(MULL_CYCLES) + PW'(opcode_i[21]);
      ClsLs:   dec_n = (opcode_i[21] || !opcode_i[24]) ? PW'(2) : PW'(1);
      ClsBlk:  dec_n = ((dec_pop == '0) ? PW'(1) : dec_pop) + PW'(opcode_i[21]);
      default: dec_n = PW'(1);
    endcase
  end

  // Beat generation: either beat 0 of a new instruction or the next beat of the current one.
  always_comb begin
    sel_cls  = accept ? dec_cls : cls_q;
    sel_op   = accept ? opcode_i[23:20] : op_q;
    sel_p    = accept ? '0 : phase_q + PW'(1);
    sel_n    = accept ? dec_n : n_q;
    sel_nx   = accept ? dec_pop : nx_q;
    sel_mask = accept ? opcode_i[NUM_REGS-1:0] : mask_q;

    b_last     = (sel_p == sel_n - PW'(1));
    b_mask_nxt = sel_mask & (sel_mask - NUM_REGS'(1));
    b_idx      = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (sel_mask[i]) b_idx = RW'(i);
    end

    c14     = '0;
    b_reg   = '0;
    off_int = 0;
    case (sel_cls)
      ClsDp:  c14 = {13'b0, sel_op[0]};
      ClsMul: c14 = {sel_op[0], 12'b000010100000, sel_op[0]};
      ClsMull: begin
        c14 = {sel_op[0], 2'b00, (sel_p != '0), 9'b010100000, sel_op[0] & b_last};
        // Accumulate form: final beat adds the accumulator instead of shifting.
        if (sel_op[1] && b_last) begin
          c14[10]  = 1'b0;
          c14[8:7] = 2'b01;
        end
      end
      ClsLs:  c14 = (sel_p == '0) ? 14'h0006 : 14'h0002;
      ClsBr:  c14 = 14'h1000;
      ClsBlk: begin
        if (sel_op[1] && b_last) begin
          c14     = 14'h0002;
          off_int = sel_op[3] ? int'(sel_nx) * int'(ADDR_STEP)
                              : -(int'(sel_nx) * int'(ADDR_STEP));
        end else if (sel_nx != '0) begin
          c14     = 14'h0206;
          b_reg   = b_idx;
          off_int = sel_op[3] ? int'(sel_p) * int'(ADDR_STEP)
                              : (int'(sel_p) - int'(sel_nx)) * int'(ADDR_STEP);
        end
      end
      default: c14 = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cls_q       <= ClsDp;
      op_q        <= '0;
      n_q         <= '0;
      nx_q        <= '0;
      phase_q     <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      reg_idx_q   <= '0;
      addr_off_q  <= '0;
    end else if (!hold_i) begin
      if (accept || (state_q == StRun && !last_q)) begin
        state_q     <= StRun;
        cls_q       <= sel_cls;
        op_q        <= sel_op;
        n_q         <= sel_n;
        nx_q        <= sel_nx;
        phase_q     <= sel_p;
        mask_q      <= b_mask_nxt;
        cnt_q       <= CNT_W'(c14);
        out_valid_q <= 1'b1;
        last_q      <= b_last;
        reg_idx_q   <= b_reg;
        addr_off_q  <= off_int[15:0];
      end else begin
        state_q     <= StIdle;
        cls_q       <= ClsDp;
        op_q        <= '0;
        n_q         <= '0;
        nx_q        <= '0;
        phase_q     <= '0;
        mask_q      <= '0;
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
        last_q      <= 1'b0;
        reg_idx_q   <= '0;
        addr_off_q  <= '0;
      end
    end
  end

  assign cnt_out_o   = cnt_q;
  assign out_valid_o = out_valid_q;
  assign phase_o     = phase_q;
  assign last_o      = last_q;
  assign reg_idx_o   = reg_idx_q;
  assign addr_off_o  = addr_off_q;

endmodule
